// File: rtl/spi_tx_fifo_feeder.sv
// TX word FIFO plus issue sequencer feeding the SPI_TX shift core.
// Words are popped one at a time and handed over with a wrt pulse / done-level handshake.
module spi_tx_fifo_feeder #(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 16,
    parameter int LOWATER = 4,
    parameter int BUSY_TO = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_valid,
    input  logic [DATA_W-1:0]      push_data,
    output logic                   push_ready,
    input  logic                   flush,
    input  logic                   en,
    output logic                   spi_wrt,
    output logic [DATA_W-1:0]      spi_tx_data,
    input  logic                   spi_done,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   busy,
    output logic                   irq_lowater,
    output logic                   ovf_err,
    output logic                   to_err,
    input  logic                   err_clr,
    output logic [15:0]            done_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(BUSY_TO) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic [15:0]       done_cnt_q, done_cnt_d;
    logic              ovf_q, ovf_d, to_err_q, to_err_d;
    logic              push_acc, pop, to_set;

    assign level       = level_q;
    assign empty       = (level_q == '0);
    assign full        = (level_q == LW'(DEPTH));
    assign push_ready  = !full && !flush;
    assign busy        = (state_q != IDLE);
    assign irq_lowater = (level_q <= LW'(LOWATER));
    assign spi_tx_data = data_q;
    assign done_cnt    = done_cnt_q;
    assign ovf_err     = ovf_q;
    assign to_err      = to_err_q;

    assign push_acc = push_valid && push_ready;
    // A flushing cycle never pops, so the flushed queue cannot leak a word into the core.
    assign pop      = (state_q == IDLE) && !empty && en && spi_done && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
            level_d = level_q + LW'(push_acc) - LW'(pop);
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        to_cnt_d   = to_cnt_q;
        done_cnt_d = done_cnt_q;
        to_set     = 1'b0;
        spi_wrt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    data_d  = mem_q[rd_ptr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                spi_wrt  = 1'b1;
                to_cnt_d = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // Core must acknowledge by dropping done; otherwise the word is abandoned.
                if (!spi_done) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == TW'(BUSY_TO - 1)) begin
                    to_set  = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (spi_done) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d    = ovf_q;
        to_err_d = to_err_q;
        if (err_clr) begin
            ovf_d    = 1'b0;
            to_err_d = 1'b0;
        end
        if (push_valid && !push_ready) ovf_d    = 1'b1;
        if (to_set)                    to_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= IDLE;
            data_q     <= '0;
            to_cnt_q   <= '0;
            done_cnt_q <= '0;
            ovf_q      <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            data_q     <= data_d;
            to_cnt_q   <= to_cnt_d;
            done_cnt_q <= done_cnt_d;
            ovf_q      <= ovf_d;
            to_err_q   <= to_err_d;
        end
    end

endmodule
